// File: rtl/rv_gpr_pkg.sv
// rtl/rv_gpr_pkg.sv - general-purpose register file types and constants
package rv_gpr_pkg;

  localparam int GPR_ADDR_W = 5;
  localparam int GPR_NUM    = 2 ** GPR_ADDR_W;

  typedef logic [GPR_ADDR_W-1:0] gpr_addr_t;

  // Which producer owns the write currently sitting in the output stage.
  typedef enum logic {
    WB_SRC_PIPE = 1'b0,
    WB_SRC_MDU  = 1'b1
  } wb_src_e;

endpackage

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - core-wide architectural constants
package rv_pkg;

  localparam int XLEN = 32;

endpackage

// File: rtl/rv_wb_fifo.sv
// rtl/rv_wb_fifo.sv - small synchronous FIFO with valid/ready push and occupancy count
module rv_wb_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic             push_valid_i,
  output logic             push_ready_o,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             pop_valid_o,
  output logic [WIDTH-1:0] pop_data_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_fire;
  logic             pop_fire;

  assign push_ready_o = (cnt_q != CNT_W'(DEPTH));
  assign pop_valid_o  = (cnt_q != '0);
  assign pop_data_o   = mem_q[rd_ptr_q];
  assign cnt_o        = cnt_q;
  assign push_fire    = push_valid_i && push_ready_o;
  assign pop_fire     = pop_i && pop_valid_o;

  // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_fire)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_fire, pop_fire})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage, written at the tail on an accepted push.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_fire) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/rv_gpr_wb.sv
// rtl/rv_gpr_wb.sv - GPR writeback arbiter for pipeline and MDU results with pending scoreboard
module rv_gpr_wb
  import rv_pkg::*;
  import rv_gpr_pkg::*;
#(
  parameter int MDU_FIFO_DEPTH = 2
) (
  input  logic                            clk_i,
  input  logic                            arstn_i,
  input  logic                            pipe_wb_valid_i,
  input  logic [GPR_ADDR_W-1:0]           pipe_wb_addr_i,
  input  logic [XLEN-1:0]                 pipe_wb_data_i,
  input  logic                            mdu_wb_valid_i,
  output logic                            mdu_wb_ready_o,
  input  logic [GPR_ADDR_W-1:0]           mdu_wb_addr_i,
  input  logic [XLEN-1:0]                 mdu_wb_data_i,
  input  logic                            sb_set_i,
  input  logic [GPR_ADDR_W-1:0]           sb_set_addr_i,
  input  logic [GPR_ADDR_W-1:0]           sb_rs1_addr_i,
  input  logic [GPR_ADDR_W-1:0]           sb_rs2_addr_i,
  input  logic [GPR_ADDR_W-1:0]           sb_rd_addr_i,
  output logic                            sb_hazard_o,
  output logic                            gpr_wr_en_o,
  output logic [GPR_ADDR_W-1:0]           gpr_wr_addr_o,
  output logic [XLEN-1:0]                 gpr_wr_data_o,
  output logic [$clog2(MDU_FIFO_DEPTH):0] mdu_fifo_cnt_o
);

  localparam int ENT_W = GPR_ADDR_W + XLEN;

  logic             fifo_valid;
  logic             fifo_pop;
  logic [ENT_W-1:0] fifo_head;
  gpr_addr_t        head_addr;
  logic [XLEN-1:0]  head_data;

  logic             wr_en_q, wr_en_d;
  gpr_addr_t        wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]  wr_data_q, wr_data_d;
  wb_src_e          src_q, src_d;

  logic [GPR_NUM-1:0] pending_q, pending_d;

  assign head_addr = fifo_head[ENT_W-1:XLEN];
  assign head_data = fifo_head[XLEN-1:0];

  // The FIFO only drains in cycles the pipeline leaves the write port idle.
  assign fifo_pop = !pipe_wb_valid_i && fifo_valid;

  rv_wb_fifo #(
    .DEPTH (MDU_FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_mdu_fifo (
    .clk_i        (clk_i),
    .arstn_i      (arstn_i),
    .push_valid_i (mdu_wb_valid_i),
    .push_ready_o (mdu_wb_ready_o),
    .push_data_i  ({mdu_wb_addr_i, mdu_wb_data_i}),
    .pop_i        (fifo_pop),
    .pop_valid_o  (fifo_valid),
    .pop_data_o   (fifo_head),
    .cnt_o        (mdu_fifo_cnt_o)
  );

  // Pick this cycle's winner; an x0 winner still consumes its slot but never writes.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = head_addr;
    wr_data_d = head_data;
    src_d     = WB_SRC_MDU;
    if (pipe_wb_valid_i) begin
      wr_en_d   = (pipe_wb_addr_i != '0);
      wr_addr_d = pipe_wb_addr_i;
      wr_data_d = pipe_wb_data_i;
      src_d     = WB_SRC_PIPE;
    end else if (fifo_valid) begin
      wr_en_d   = (head_addr != '0);
    end
  end

  // Output stage toward the register file.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      src_q     <= WB_SRC_PIPE;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      src_q     <= src_d;
    end
  end

  assign gpr_wr_en_o   = wr_en_q;
  assign gpr_wr_addr_o = wr_addr_q;
  assign gpr_wr_data_o = wr_data_q;

  // Scoreboard update: MDU writes leaving the output stage clear, issues set; set is applied last so it wins.
  always_comb begin
    pending_d = pending_q;
    if (wr_en_q && (src_q == WB_SRC_MDU)) pending_d[wr_addr_q] = 1'b0;
    if (sb_set_i && (sb_set_addr_i != '0)) pending_d[sb_set_addr_i] = 1'b1;
  end

  // Pending vector register; x0 is never set, so its bit stays zero.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) pending_q <= '0;
    else          pending_q <= pending_d;
  end

  assign sb_hazard_o = pending_q[sb_rs1_addr_i] | pending_q[sb_rs2_addr_i] | pending_q[sb_rd_addr_i];

endmodule

// File: tb/tb_rv_gpr_wb.sv
// tb/tb_rv_gpr_wb.sv - self-checking bench for rv_gpr_wb against a queue-based reference model
module tb_rv_gpr_wb;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        arstn;
  logic        pipe_v;
  logic [4:0]  pipe_a;
  logic [31:0] pipe_d;
  logic        mdu_v;
  logic        mdu_rdy;
  logic [4:0]  mdu_a;
  logic [31:0] mdu_d;
  logic        sb_set;
  logic [4:0]  sb_a;
  logic [4:0]  rs1, rs2, rd;
  logic        hazard;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [$clog2(DEPTH):0] cnt;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        m_q[$];
  bit          m_pend[32];
  bit          m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_src_mdu;

  always #5 clk = ~clk;

  rv_gpr_wb #(.MDU_FIFO_DEPTH(DEPTH)) dut (
    .clk_i           (clk),
    .arstn_i         (arstn),
    .pipe_wb_valid_i (pipe_v),
    .pipe_wb_addr_i  (pipe_a),
    .pipe_wb_data_i  (pipe_d),
    .mdu_wb_valid_i  (mdu_v),
    .mdu_wb_ready_o  (mdu_rdy),
    .mdu_wb_addr_i   (mdu_a),
    .mdu_wb_data_i   (mdu_d),
    .sb_set_i        (sb_set),
    .sb_set_addr_i   (sb_a),
    .sb_rs1_addr_i   (rs1),
    .sb_rs2_addr_i   (rs2),
    .sb_rd_addr_i    (rd),
    .sb_hazard_o     (hazard),
    .gpr_wr_en_o     (wr_en),
    .gpr_wr_addr_o   (wr_addr),
    .gpr_wr_data_o   (wr_data),
    .mdu_fifo_cnt_o  (cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    pipe_v = 0; pipe_a = 0; pipe_d = 0;
    mdu_v  = 0; mdu_a  = 0; mdu_d  = 0;
    sb_set = 0; sb_a   = 0;
    rs1 = 0; rs2 = 0; rd = 0;
  endtask

  task automatic model_reset();
    m_q.delete();
    foreach (m_pend[i]) m_pend[i] = 0;
    m_en = 0; m_addr = 0; m_data = 0; m_src_mdu = 0;
  endtask

  // One clock edge of the architectural behaviour, evaluated on the inputs seen at that edge.
  task automatic model_step();
    bit   push;
    ent_t e;
    push = mdu_v && (m_q.size() < DEPTH);
    if (m_en && m_src_mdu) m_pend[m_addr] = 0;
    if (sb_set && sb_a != 0) m_pend[sb_a] = 1;
    if (pipe_v) begin
      m_en = (pipe_a != 0); m_addr = pipe_a; m_data = pipe_d; m_src_mdu = 0;
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      m_en = (e.a != 0); m_addr = e.a; m_data = e.d; m_src_mdu = 1;
    end else begin
      m_en = 0;
    end
    if (push) m_q.push_back('{a: mdu_a, d: mdu_d});
  endtask

  task automatic check_model();
    chk("wr_en", wr_en, m_en);
    if (m_en) begin
      chk("wr_addr", wr_addr, m_addr);
      chk("wr_data", wr_data, m_data);
    end
    chk("mdu_ready", mdu_rdy, m_q.size() < DEPTH);
    chk("fifo_cnt", cnt, m_q.size());
    chk("hazard", hazard, m_pend[rs1] | m_pend[rs2] | m_pend[rd]);
  endtask

  // Check at the falling edge, advance the model on the rising edge, return just after it.
  task automatic cyc();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    logic [31:0] d1, d2, d3;
    idle();
    model_reset();
    arstn = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", wr_en, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_ready", mdu_rdy, 1);
    chk("rst_hazard", hazard, 0);
    arstn = 1;

    // Pipe only
    pipe_v = 1; pipe_a = 5; pipe_d = 32'hDEADBEEF;
    cyc();
    idle();
    chk("t1_en", wr_en, 1);
    chk("t1_addr", wr_addr, 5);
    chk("t1_data", wr_data, 32'hDEADBEEF);
    cyc();
    chk("t1_en_off", wr_en, 0);

    // Scoreboard round trip
    sb_set = 1; sb_a = 7; rs1 = 7;
    cyc();
    sb_set = 0; sb_a = 0;
    cyc(); cyc();
    mdu_v = 1; mdu_a = 7; mdu_d = 32'h12345678;
    cyc();
    mdu_v = 0; mdu_a = 0; mdu_d = 0;
    cyc();
    chk("t2_en", wr_en, 1);
    chk("t2_addr", wr_addr, 7);
    chk("t2_data", wr_data, 32'h12345678);
    chk("t2_hazard_c5", hazard, 1);
    cyc();
    chk("t2_hazard_c6", hazard, 0);
    idle();

    // Priority: queued MDU result waits behind three pipeline writes
    mdu_v = 1; mdu_a = 3; mdu_d = 32'h0000_0333;
    cyc();
    mdu_v = 0;
    for (int i = 0; i < 3; i++) begin
      pipe_v = 1; pipe_a = 4; pipe_d = 32'h0000_0400 + i;
      cyc();
    end
    idle();
    cyc();
    chk("t3_mdu_addr", wr_addr, 3);
    chk("t3_mdu_en", wr_en, 1);
    cyc();

    // Full FIFO with the pipeline hogging the port
    d1 = $urandom; d2 = $urandom; d3 = $urandom;
    pipe_v = 1; pipe_a = 1; pipe_d = $urandom;
    mdu_v = 1; mdu_a = 10; mdu_d = d1;
    cyc();
    mdu_a = 11; mdu_d = d2;
    cyc();
    mdu_a = 12; mdu_d = d3;
    chk("t4_ready_full", mdu_rdy, 0);
    chk("t4_cnt_full", cnt, 2);
    cyc();
    cyc();
    pipe_v = 0;
    cyc();
    chk("t4_drain1", wr_data, d1);
    cyc();
    mdu_v = 0;
    chk("t4_drain2", wr_data, d2);
    cyc();
    chk("t4_drain3", wr_data, d3);
    cyc();
    idle();

    // x0 handling
    pipe_v = 1; pipe_a = 0; pipe_d = 32'hFFFF_FFFF;
    cyc();
    idle();
    chk("t5_x0_en", wr_en, 0);
    sb_set = 1; sb_a = 0;
    cyc();
    idle();
    chk("t5_x0_hazard", hazard, 0);

    // Same-edge set and clear on x9
    sb_set = 1; sb_a = 9;
    cyc();
    idle();
    mdu_v = 1; mdu_a = 9; mdu_d = 32'h9999_0009;
    cyc();
    idle();
    cyc();
    chk("t6_mdu_write9", wr_addr, 9);
    sb_set = 1; sb_a = 9;
    cyc();
    idle();
    rs2 = 9;
    cyc();
    chk("t6_set_wins", hazard, 1);

    // Asynchronous reset in the middle of a drain
    pipe_v = 1; pipe_a = 2; pipe_d = 32'h2;
    mdu_v = 1; mdu_a = 13; mdu_d = 32'hAAAA;
    sb_set = 1; sb_a = 13;
    cyc();
    mdu_a = 14; mdu_d = 32'hBBBB; sb_a = 14;
    cyc();
    idle();
    rs1 = 13; rs2 = 14; rd = 9;
    cyc();
    #2;
    arstn = 0;
    #1;
    model_reset();
    chk("t6_rst_en", wr_en, 0);
    chk("t6_rst_addr", wr_addr, 0);
    chk("t6_rst_data", wr_data, 0);
    chk("t6_rst_cnt", cnt, 0);
    chk("t6_rst_ready", mdu_rdy, 1);
    chk("t6_rst_hazard", hazard, 0);
    @(posedge clk);
    #1;
    arstn = 1;
    idle();

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      pipe_v = ($urandom_range(0, 2) == 0);
      pipe_a = 5'($urandom_range(0, 15));
      pipe_d = $urandom;
      mdu_v  = ($urandom_range(0, 4) < 2);
      mdu_a  = 5'($urandom_range(0, 15));
      mdu_d  = $urandom;
      sb_set = ($urandom_range(0, 3) == 0);
      sb_a   = 5'($urandom_range(0, 15));
      rs1    = 5'($urandom_range(0, 15));
      rs2    = 5'($urandom_range(0, 15));
      rd     = 5'($urandom_range(0, 15));
      cyc();
    end
    idle();
    repeat (4) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_gpr_wb.md
Name: rv_gpr_wb

Overview:
- Writeback side of the GPR write port: arbitrates the single-cycle pipeline result and the multi-cycle MDU (mul/div) result onto one `wr_en/wr_addr/wr_data` port.
- Buffers MDU results in a small FIFO.
- Keeps a per-register pending scoreboard so issue logic can stall on RAW/WAW against outstanding MDU operations.
- Sits between the execute/MDU stages and the general-purpose register file.

Parameters:
- MDU_FIFO_DEPTH, 2, MDU result buffer entries; power of two, ≥2.
- XLEN (32) comes from rv_pkg; GPR_ADDR_W (5) comes from rv_gpr_pkg. Neither is overridden locally.

Ports:
- clk_i  in  1  clock
- arstn_i  in  1  asynchronous active-low reset
- pipe_wb_valid_i  in  1  pipeline writeback request; no backpressure, always accepted
- pipe_wb_addr_i  in  GPR_ADDR_W  pipeline destination register
- pipe_wb_data_i  in  XLEN  pipeline result
- mdu_wb_valid_i  in  1  MDU result valid
- mdu_wb_ready_o  out  1  FIFO not full
- mdu_wb_addr_i  in  GPR_ADDR_W  MDU destination register
- mdu_wb_data_i  in  XLEN  MDU result
- sb_set_i  in  1  MDU op issued; mark destination pending
- sb_set_addr_i  in  GPR_ADDR_W  destination register of the issued MDU op
- sb_rs1_addr_i  in  GPR_ADDR_W  query: source 1
- sb_rs2_addr_i  in  GPR_ADDR_W  query: source 2
- sb_rd_addr_i  in  GPR_ADDR_W  query: destination
- sb_hazard_o  out  1  any queried register pending (combinational from the pending vector)
- gpr_wr_en_o  out  1  GPR write enable
- gpr_wr_addr_o  out  GPR_ADDR_W  GPR write address
- gpr_wr_data_o  out  XLEN  GPR write data
- mdu_fifo_cnt_o  out  $clog2(MDU_FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset values (async, all state):
  - gpr_wr_en_o, gpr_wr_addr_o, gpr_wr_data_o = 0
  - FIFO empty, pointers 0, mdu_fifo_cnt_o = 0, mdu_wb_ready_o = 1
  - pending vector all 0, so sb_hazard_o = 0
- Output stage:
  - gpr_wr_* is a register stage.
  - A winning request in cycle N appears on gpr_wr_* in cycle N+1 for exactly one cycle.
- Arbitration, each cycle:
  - If pipe_wb_valid_i is high, the pipeline wins.
  - Otherwise, if the FIFO is non-empty, the FIFO head wins and is popped.
  - Otherwise the next gpr_wr_en_o is 0.
  - The pipeline has strict priority; MDU starvation is prevented upstream by the scoreboard stall.
- FIFO:
  - Push when mdu_wb_valid_i && mdu_wb_ready_o.
  - The head is eligible for arbitration the cycle after the push. Earliest GPR write is therefore at push+2.
  - Simultaneous push and pop when full is not possible, because ready is low when full.
  - Simultaneous push and pop otherwise leaves the count unchanged.
  - Pointers wrap modulo MDU_FIFO_DEPTH.
  - When full, a valid MDU request is held off and the FIFO is unchanged.
- x0 handling:
  - A winning request with addr==0 drives gpr_wr_en_o=0 but still consumes its slot (FIFO pop happens).
  - sb_set_i with addr 0 is ignored.
  - Queries of x0 never flag a hazard.
- Scoreboard:
  - pending[sb_set_addr_i] is set at the edge when sb_set_i is high.
  - pending[a] is cleared at the edge ending the cycle in which gpr_wr_en_o=1, gpr_wr_addr_o=a, and the output-stage source flag = MDU. This is the same edge the GPR captures the data, so a reader in the next cycle sees the new value.
  - Set and clear of the same address on the same edge: set wins.
  - Pipeline writes never modify the pending vector.
  - sb_hazard_o = pending[rs1] | pending[rs2] | pending[rd].
- Protocol assumption: the issue stage stalls on sb_hazard_o. The block does not check for a double set of an already-pending register; it stays set.
- Reset mid-operation: FIFO contents and pending bits are discarded; the in-flight output write is dropped.

Decomposition:
- rv_gpr_pkg gains:
  - GPR_NUM = 2**GPR_ADDR_W
  - typedef gpr_addr_t
  - typedef wb_src_e {WB_SRC_PIPE, WB_SRC_MDU}, used for the output-stage source flag
- One natural sub-module, rv_wb_fifo: a parameterised synchronous FIFO with valid/ready push, pop, count, and async active-low reset. Reusable by the LSU.

Test Plan:
1. Pipe only: pipe valid, addr=5, data=0xDEADBEEF in cycle 0 → gpr_wr_en_o=1, addr 5, data 0xDEADBEEF in cycle 1; gpr_wr_en_o=0 in cycle 2.
2. Scoreboard round trip: sb_set addr=7 at cycle 0; MDU push addr=7, data=0x12345678 at cycle 3 → gpr write at cycle 5; sb_hazard_o with rs1=7 is 1 in cycles 1–5 and 0 in cycle 6.
3. Priority: FIFO holds addr=3; pipe valid addr=4 for cycles 0–2 → GPR writes addr 4 in cycles 1–3, addr 3 in cycle 4.
4. Full FIFO (DEPTH=2): three consecutive MDU pushes with pipe continuously valid → ready=0 on the third, mdu_fifo_cnt_o=2, no data lost. After the pipe idles, the entries drain in order.
5. x0: pipe addr=0 → gpr_wr_en_o stays 0. sb_set addr=0 → sb_hazard_o stays 0 for rs1=0.
6. Same-edge set/clear: MDU write to addr 9 on gpr_wr_* while sb_set addr=9 → pending[9] remains 1. Async reset mid-drain → all outputs 0 and count 0 immediately.
